// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of a single-port SRAM for a load/store stage.
// Takes one load/store request at a time, performs a single SRAM access, and
// returns aligned, sign/zero-extended load data or an error response.
//
// Optional feature macro: MEM_RANGE_CHECK_EN
//   defined   -> a request with address bits above AWIDTH+1 set is an error
//   undefined -> those bits are ignored (address wraps)
//
// Ports:
//   CLK, RSTn                 clock, synchronous active-low reset
//   req_valid / req_ready     request handshake
//   req_we, req_size,         store flag, size (00 byte, 01 half, 10 word),
//   req_unsigned              zero-extend loads when set
//   req_addr, req_wdata       byte address, right-justified store data
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata, rsp_err        formatted load data, rejected-request flag
//   MEM_CSN, MEM_ADDR,        SRAM chip select (active low), word address,
//   MEM_WEN, MEM_BE, MEM_DI   write enable (0 = write), byte lanes, write data
//   MEM_DOUT                  SRAM read data, valid the cycle after the read
module mem_access_unit #(
  parameter int unsigned AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              MEM_CSN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT, RESP} state_t;

  state_t state, state_nxt;

  // Request fields kept for the access and the load formatting
  logic       lat_we, lat_uns;
  logic [1:0] lat_size, lat_off;
  logic       lat_we_nxt, lat_uns_nxt;
  logic [1:0] lat_size_nxt, lat_off_nxt;

  logic              csn_nxt, wen_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [AWIDTH-1:0] addr_nxt;
  logic [3:0]        be_nxt;
  logic [31:0]       di_nxt, rsp_rdata_nxt;

  logic        req_accept, req_err, size_err, align_err, range_err, addr_hi_nz;
  logic [3:0]  req_be;
  logic [31:0] req_di;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready  = (state == IDLE) & RSTn;
  assign req_accept = req_valid & req_ready;

  // Request classification
  assign addr_hi_nz = |(req_addr >> (AWIDTH + 2));
  assign size_err   = (req_size == 2'b11);
  assign align_err  = ((req_size == 2'b01) & req_addr[0]) |
                      ((req_size == 2'b10) & (|req_addr[1:0]));
`ifdef MEM_RANGE_CHECK_EN
  assign range_err  = addr_hi_nz;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = addr_hi_nz;
  assign range_err      = 1'b0;
`endif
  assign req_err = size_err | align_err | range_err;

  // Byte lanes and replicated write data for the incoming request
  always_comb begin : req_lanes
    req_be = 4'b0000;
    req_di = 32'h0;
    case (req_size)
      2'b00: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_di = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be = 4'b0011 << {req_addr[1], 1'b0};
        req_di = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_di = req_wdata;
      end
    endcase
    if (!req_we) req_di = 32'h0;
  end

  // Load alignment and extension from the captured read word
  always_comb begin : load_format
    ld_byte = MEM_DOUT[7:0];
    case (lat_off)
      2'd1:    ld_byte = MEM_DOUT[15:8];
      2'd2:    ld_byte = MEM_DOUT[23:16];
      2'd3:    ld_byte = MEM_DOUT[31:24];
      default: ld_byte = MEM_DOUT[7:0];
    endcase
    ld_half = lat_off[1] ? MEM_DOUT[31:16] : MEM_DOUT[15:0];
    case (lat_size)
      2'b00:   ld_data = lat_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = lat_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = MEM_DOUT;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin : state_reg
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:      if (req_accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:    state_nxt = lat_we ? RESP : READ_WAIT;
      READ_WAIT: state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and latched request fields
  always_comb begin : out_comb
    csn_nxt       = MEM_CSN;
    wen_nxt       = MEM_WEN;
    addr_nxt      = MEM_ADDR;
    be_nxt        = MEM_BE;
    di_nxt        = MEM_DI;
    rsp_valid_nxt = rsp_valid;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    lat_we_nxt    = lat_we;
    lat_uns_nxt   = lat_uns;
    lat_size_nxt  = lat_size;
    lat_off_nxt   = lat_off;
    case (state)
      IDLE: begin
        if (req_accept) begin
          lat_we_nxt   = req_we;
          lat_uns_nxt  = req_unsigned;
          lat_size_nxt = req_size;
          lat_off_nxt  = req_addr[1:0];
          if (req_err) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = 32'h0;
          end else begin
            csn_nxt  = 1'b0;
            wen_nxt  = ~req_we;
            addr_nxt = req_addr[AWIDTH+1:2];
            be_nxt   = req_be;
            di_nxt   = req_di;
          end
        end
      end
      ACCESS: begin
        csn_nxt = 1'b1;
        wen_nxt = 1'b1;
        be_nxt  = 4'b0000;
        if (lat_we) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = 32'h0;
        end
      end
      READ_WAIT: begin
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = ld_data;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = 32'h0;
        end
      end
      default: ;
    endcase
  end

  // Output and request-field registers
  always_ff @(posedge CLK) begin : out_reg
    if (!RSTn) begin
      MEM_CSN   <= 1'b1;
      MEM_WEN   <= 1'b1;
      MEM_ADDR  <= '0;
      MEM_BE    <= 4'b0000;
      MEM_DI    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= 2'b00;
      lat_off   <= 2'b00;
    end else begin
      MEM_CSN   <= csn_nxt;
      MEM_WEN   <= wen_nxt;
      MEM_ADDR  <= addr_nxt;
      MEM_BE    <= be_nxt;
      MEM_DI    <= di_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      lat_we    <= lat_we_nxt;
      lat_uns   <= lat_uns_nxt;
      lat_size  <= lat_size_nxt;
      lat_off   <= lat_off_nxt;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-port SRAM interface: the block a RISC-V core's load/store stage uses to drive SP_SRAM-style memories.
- Accepts one load/store request at a time over a valid/ready handshake, then drives chip-select, word address, active-low write enable, byte enables and write data.
- Captures read data one cycle after the SRAM access and returns it aligned and sign/zero extended.
- Responses use a valid/ready handshake with an error flag.

Parameters:
- AWIDTH, 12, SRAM word-address width; byte address bits [AWIDTH+1:2] select the word.

Ports:
- CLK  input  1  clock; all logic on posedge
- RSTn  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  32  formatted load data; 0 for stores and errors
- rsp_err  output  1  request rejected, no SRAM access made
- MEM_CSN  output  1  SRAM chip select, active low
- MEM_ADDR  output  AWIDTH  SRAM word address
- MEM_WEN  output  1  1 = read, 0 = write
- MEM_BE  output  4  byte-lane enables
- MEM_DI  output  32  SRAM write data
- MEM_DOUT  input  32  SRAM read data; valid after the posedge that sampled a read

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset is synchronous and active-low on RSTn.
  - While RSTn = 0 at a posedge: state becomes IDLE, MEM_CSN = 1, MEM_WEN = 1, MEM_ADDR = 0, MEM_BE = 0, MEM_DI = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - req_ready = (state == IDLE) & RSTn.
  - Reset mid-operation abandons the in-flight request; no response is produced and no further SRAM access is made.
- States: IDLE, ACCESS, READ_WAIT, RESP.
- IDLE:
  - On req_valid & req_ready, latch the request (address, size, unsigned, we, wdata).
  - If the request is an error: go to RESP with rsp_err = 1; MEM_CSN stays 1.
  - Otherwise: register MEM_CSN = 0, MEM_WEN = ~req_we, MEM_ADDR = req_addr[AWIDTH+1:2], MEM_BE and MEM_DI as below, and go to ACCESS.
- Error conditions:
  - req_size = 11.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
- ACCESS: the SRAM samples at this posedge.
  - Next state: MEM_CSN = 1, MEM_WEN = 1, MEM_BE = 0.
  - Store: go to RESP (rsp_err = 0, rsp_rdata = 0).
  - Load: go to READ_WAIT.
- READ_WAIT: capture MEM_DOUT, format it into rsp_rdata, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency, request accept edge to rsp_valid high:
  - Store: 2 cycles.
  - Load: 3 cycles.
  - Error: 1 cycle.
- Byte enables, with o = addr[1:0]:
  - Byte: BE = 4'b0001 << o.
  - Half: BE = 4'b0011 << (2·addr[1]).
  - Word: BE = 4'b1111.
- Write data:
  - Byte: MEM_DI = {4{wdata[7:0]}}.
  - Half: MEM_DI = {2{wdata[15:0]}}.
  - Word: MEM_DI = wdata.
  - Loads: MEM_DI = 0.
- Load formatting:
  - Shift: s = DOUT >> (8·o).
  - Byte: result from s[7:0], extended from bit 7 unless unsigned.
  - Half: result from s[15:0], extended from bit 15 unless unsigned.
  - Word: result = DOUT, unchanged.
- Address bits above AWIDTH+1 are ignored unless the optional feature is compiled in.
- Only one request is outstanding at any time; MEM_CSN is low for exactly one cycle per valid request.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: a request with req_addr[31:AWIDTH+2] != 0 is also an error (rsp_err = 1, no SRAM access, 1-cycle latency). Misalignment and range errors are not distinguished.
- Undefined: the upper address bits are ignored and the address wraps modulo 2^(AWIDTH+2) bytes.

Test Plan:
- Store word addr 0x10, data 0xDEADBEEF -> MEM_ADDR = 4, BE = 1111, WEN = 0 for one cycle. Then load word 0x10 -> rsp_rdata = 0xDEADBEEF 3 cycles after accept, rsp_err = 0.
- Store byte 0x80 to addr 0x13 over word 0x11223344 -> BE = 1000, DI = 0x80808080. Word reads 0x80223344. Byte load 0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half load addr 0x12 from word 0x8001_7FFF, signed -> 0xFFFF8001. Half load addr 0x10 -> 0x00007FFF.
- Word load at addr 0x11, half at 0x13, size = 11 -> rsp_err = 1 one cycle after accept, MEM_CSN never low, rsp_rdata = 0.
- Hold rsp_ready = 0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready = 0. Release -> rsp_valid drops and req_ready returns next cycle.
- Assert RSTn = 0 in READ_WAIT -> no rsp_valid ever for that request, all outputs at reset values. A following load returns correct data.
- With MEM_RANGE_CHECK_EN, load addr 0x4000 at AWIDTH = 12 -> rsp_err = 1. Without it -> reads word 0.
